// File: rtl/game_pkg.sv
// game_pkg: state encodings, colour constants and the tick-speedup helper shared by the game blocks
package game_pkg;
  localparam logic [1:0] STATE_START = 2'b00;
  localparam logic [1:0] STATE_PLAY  = 2'b01;
  localparam logic [1:0] STATE_OVER  = 2'b10;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;
  typedef enum logic [1:0] {
    ST_START = STATE_START,
    ST_PLAY  = STATE_PLAY,
    ST_OVER  = STATE_OVER
  } game_state_e;
  // fall rate doubles every 8 lines, capped at 8x
  function automatic int unsigned speed_shift(input int unsigned lines);
    return (lines >> 3) > 3 ? 3 : lines >> 3;
  endfunction
endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: key inputs, datapath status and sequencer outputs of the game flow controller
interface game_flow_ctrl_if #(parameter int SCORE_W = 8);
  logic               start_key, left_key, right_key, down_key;
  logic               game_over, line_cleared;
  logic [1:0]         game_state;
  logic               tick, left_req, right_req, down_req;
  logic [SCORE_W-1:0] score;
  modport master (
    input  start_key, left_key, right_key, down_key, game_over, line_cleared,
    output game_state, tick, left_req, right_req, down_req, score
  );
  modport slave (
    output start_key, left_key, right_key, down_key, game_over, line_cleared,
    input  game_state, tick, left_req, right_req, down_req, score
  );
endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync: two-flop synchronizer followed by a registered rising-edge pulse
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic edge_o
);
  logic [1:0] sync_q;
  logic       prev_q, edge_q;
  // synchronize, remember the last level, and pulse once per rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      prev_q <= sync_q[1];
      edge_q <= sync_q[1] & ~prev_q;
    end
  assign edge_o = edge_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game state machine, fall-tick timebase, per-tick move requests and line score
// Optional build macro GAME_SPEEDUP_EN shortens the tick period as the score grows.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int OVER_HOLD = 2,
  parameter int SCORE_W   = 8
) (
  input logic              CLK_50M,
  input logic              RST_N,
  game_flow_ctrl_if.master bus
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(OVER_HOLD + 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  game_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, period;
  logic [HW-1:0]      hold_q, hold_d;
  logic [2:0]         flag_q, flag_d, keep, req_q, req_d;
  logic               tick_q, tick_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_e, left_e, right_e, down_e;
  logic               state_chg, wrap, flag_live;
  key_edge_sync u_start (.clk(CLK_50M), .rst_n(RST_N), .key_i(bus.start_key), .edge_o(start_e));
  key_edge_sync u_left  (.clk(CLK_50M), .rst_n(RST_N), .key_i(bus.left_key),  .edge_o(left_e));
  key_edge_sync u_right (.clk(CLK_50M), .rst_n(RST_N), .key_i(bus.right_key), .edge_o(right_e));
  key_edge_sync u_down  (.clk(CLK_50M), .rst_n(RST_N), .key_i(bus.down_key),  .edge_o(down_e));
  assign state_chg = state_d != state_q;
  assign wrap      = state_q != ST_START && cnt_q == period - CW'(1);
  assign flag_live = state_q == ST_PLAY && !state_chg;
`ifdef GAME_SPEEDUP_EN
  logic [CW-1:0] period_q, period_d;
  assign period_d = (state_chg || wrap) ? CW'(TICK_DIV >> speed_shift(32'(score_d))) : period_q;
  // period relatches only at a wrap or a state entry so a running count never changes length
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) period_q <= CW'(TICK_DIV);
    else        period_q <= period_d;
  assign period = period_q;
`else
  assign period = CW'(TICK_DIV);
`endif
  // next game state; an illegal encoding falls back to START
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = start_e ? ST_PLAY : ST_START;
      ST_PLAY:  state_d = bus.game_over ? ST_OVER : ST_PLAY;
      ST_OVER:  state_d = (start_e && hold_q >= HW'(OVER_HOLD)) ? ST_START : ST_OVER;
      default:  state_d = ST_START;
    endcase
  end
  // timebase, OVER hold count, sticky move flags and score
  always_comb begin
    cnt_d     = (state_chg || state_q == ST_START || wrap) ? '0 : cnt_q + 1'b1;
    hold_d    = state_chg ? '0 :
                (state_q == ST_OVER && wrap && hold_q < HW'(OVER_HOLD)) ? hold_q + 1'b1 : hold_q;
    tick_d    = state_q == ST_PLAY && wrap;
    keep      = tick_q ? 3'b000 : flag_q;
    flag_d[0] = flag_live & (left_e ? ~right_e : (right_e ? 1'b0 : keep[0]));
    flag_d[1] = flag_live & (right_e ? ~left_e : (left_e ? 1'b0 : keep[1]));
    flag_d[2] = flag_live & (down_e | keep[2]);
    req_d     = tick_d ? flag_d : 3'b000;
    score_d   = (state_q == ST_START && state_d == ST_PLAY) ? '0 :
                (state_q == ST_PLAY && bus.line_cleared && score_q != SCORE_MAX) ? score_q + 1'b1 : score_q;
  end
  // state and output registers
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      state_q <= ST_START;
      cnt_q   <= '0;
      hold_q  <= '0;
      flag_q  <= '0;
      req_q   <= '0;
      tick_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      flag_q  <= flag_d;
      req_q   <= req_d;
      tick_q  <= tick_d;
      score_q <= score_d;
    end
  assign bus.game_state = state_q;
  assign bus.tick       = tick_q;
  assign bus.left_req   = req_q[0];
  assign bus.right_req  = req_q[1];
  assign bus.down_req   = req_q[2];
  assign bus.score      = score_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed stimulus with a cycle model of the game rules and literal spot checks
module tb_game_flow_ctrl;
  localparam int P = 10, HOLD = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_key = 0, left_key = 0, right_key = 0, down_key = 0, game_over = 0, line_cleared = 0;
  int   checks = 0, errors = 0;
  bit   check_en = 0;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(8)) bm ();
  game_flow_ctrl_if #(.SCORE_W(2)) b2 ();
  assign bm.start_key = start_key;  assign b2.start_key = start_key;
  assign bm.left_key = left_key;    assign b2.left_key = left_key;
  assign bm.right_key = right_key;  assign b2.right_key = right_key;
  assign bm.down_key = down_key;    assign b2.down_key = down_key;
  assign bm.game_over = game_over;  assign b2.game_over = game_over;
  assign bm.line_cleared = line_cleared; assign b2.line_cleared = line_cleared;
  game_flow_ctrl #(.TICK_DIV(P), .OVER_HOLD(HOLD), .SCORE_W(8)) dut  (.CLK_50M(clk), .RST_N(rst_n), .bus(bm));
  game_flow_ctrl #(.TICK_DIV(P), .OVER_HOLD(HOLD), .SCORE_W(2)) dut2 (.CLK_50M(clk), .RST_N(rst_n), .bus(b2));
`ifdef GAME_SPEEDUP_EN
  logic lc3 = 0;
  game_flow_ctrl_if #(.SCORE_W(8)) bs ();
  assign bs.start_key = start_key; assign bs.left_key = 1'b0; assign bs.right_key = 1'b0;
  assign bs.down_key = 1'b0; assign bs.game_over = 1'b0; assign bs.line_cleared = lc3;
  game_flow_ctrl #(.TICK_DIV(80), .OVER_HOLD(HOLD), .SCORE_W(8)) dut3 (.CLK_50M(clk), .RST_N(rst_n), .bus(bs));
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: state, cycles spent in it, pending moves since the last tick, and lines counted this game
  int       m_state = 0, m_age = 0, m_count = 0, m_next;
  bit [3:0] hs = 0, hl = 0, hr = 0, hd = 0;
  bit       ps, pl, pr, pd, e_tick = 0;
  bit [2:0] pend = 0, e_req = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_age = 0; m_count = 0; hs = 0; hl = 0; hr = 0; hd = 0;
      pend = 0; e_tick = 0; e_req = 0;
    end else begin
      ps = hs[2] & ~hs[3]; pl = hl[2] & ~hl[3]; pr = hr[2] & ~hr[3]; pd = hd[2] & ~hd[3];
      if (e_tick) pend = 0;
      if (m_state == 1) begin
        if (pl && pr) pend[1:0] = 2'b00;
        else if (pl) pend[1:0] = 2'b01;
        else if (pr) pend[1:0] = 2'b10;
        if (pd) pend[2] = 1'b1;
      end
      m_next = m_state;
      if (m_state == 0 && ps) m_next = 1;
      else if (m_state == 1 && game_over) m_next = 2;
      else if (m_state == 2 && ps && m_age / P >= HOLD) m_next = 0;
      if (m_state == 1 && line_cleared) m_count++;
      if (m_state == 0 && m_next == 1) m_count = 0;
      e_tick = m_state == 1 && (m_age + 1) % P == 0;
      if (m_next != m_state) begin pend = 0; m_age = 0; end
      else m_age++;
      e_req = e_tick ? pend : 3'b000;
      m_state = m_next;
      hs = {hs[2:0], start_key}; hl = {hl[2:0], left_key};
      hr = {hr[2:0], right_key}; hd = {hd[2:0], down_key};
    end
  end

  always @(posedge clk) begin
    #1;
    if (check_en && rst_n) begin
      chk("state", int'(bm.game_state), m_state);
      chk("tick", int'(bm.tick), int'(e_tick));
      chk("left_req", int'(bm.left_req), int'(e_req[0]));
      chk("right_req", int'(bm.right_req), int'(e_req[1]));
      chk("down_req", int'(bm.down_req), int'(e_req[2]));
      chk("score", int'(bm.score), m_count > 255 ? 255 : m_count);
      chk("score_w2", int'(b2.score), m_count > 3 ? 3 : m_count);
    end
  end

  function automatic bit sel(input int which);
    case (which)
      0: return bm.game_state == 2'b01;
      1: return bm.tick;
      2: return bm.game_state == 2'b00;
`ifdef GAME_SPEEDUP_EN
      3: return bs.tick;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sel(which) && n < limit);
  endtask

  task automatic pulse_lines(input int k);
    repeat (k) begin line_cleared = 1; @(negedge clk); line_cleared = 0; @(negedge clk); end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bm.game_state), 0);
    chk("rst_tick", int'(bm.tick), 0);
    chk("rst_score", int'(bm.score), 0);
    rst_n = 1; check_en = 1;
    repeat (2) @(negedge clk);
    start_key = 1;
    wait_sig(0, 20, n); chk("start_latency", n, 4);
    wait_sig(1, 30, n); chk("first_tick", n, 10);
    wait_sig(1, 30, n); chk("tick_period", n, 10);
    @(negedge clk); start_key = 0; left_key = 1;
    wait_sig(1, 30, n); chk("tick_after_left", n, 10);
    chk("left_req_set", int'(bm.left_req), 1);
    chk("left_only", int'(bm.right_req), 0);
    wait_sig(1, 30, n); chk("held_key_once", int'(bm.left_req), 0);
    @(negedge clk); left_key = 0;
    repeat (2) @(negedge clk);
    left_key = 1; right_key = 1;
    wait_sig(1, 30, n);
    chk("cancel_left", int'(bm.left_req), 0);
    chk("cancel_right", int'(bm.right_req), 0);
    @(negedge clk); left_key = 0; right_key = 0;
    repeat (2) @(negedge clk);
    left_key = 1; down_key = 1;
    repeat (2) @(negedge clk);
    right_key = 1;
    wait_sig(1, 30, n);
    chk("rl_left", int'(bm.left_req), 0);
    chk("rl_right", int'(bm.right_req), 1);
    chk("rl_down", int'(bm.down_req), 1);
    @(negedge clk); left_key = 0; right_key = 0; down_key = 0;
    pulse_lines(3);
    chk("score3", int'(bm.score), 3);
    pulse_lines(2);
    chk("score5", int'(bm.score), 5);
    chk("score_sat_w2", int'(b2.score), 3);
    wait_sig(1, 30, n);
    repeat (2) @(negedge clk);
    game_over = 1;
    @(posedge clk); #1;
    chk("over_state", int'(bm.game_state), 2);
    repeat (5) @(negedge clk);
    start_key = 1;
    repeat (2) @(negedge clk);
    start_key = 0;
    repeat (4) @(negedge clk);
    chk("early_restart_ignored", int'(bm.game_state), 2);
    chk("over_no_tick", int'(bm.tick), 0);
    repeat (14) @(negedge clk);
    start_key = 1;
    wait_sig(2, 20, n); chk("restart_latency", n, 4);
    @(negedge clk); start_key = 0; game_over = 0;
    chk("score_hold_start", int'(bm.score), 5);
    pulse_lines(2);
    chk("score_start_ignored", int'(bm.score), 5);
    repeat (2) @(negedge clk);
    start_key = 1;
    wait_sig(0, 20, n); chk("new_game_latency", n, 4);
    chk("new_game_score", int'(bm.score), 0);
    @(negedge clk); start_key = 0;
    pulse_lines(2);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", int'(bm.game_state), 0);
    chk("async_rst_score", int'(bm.score), 0);
    chk("async_rst_tick", int'(bm.tick), 0);
    @(negedge clk); rst_n = 1;
    repeat (20) @(negedge clk);
    chk("start_hold_after_rst", int'(bm.game_state), 0);
    start_key = 1;
    wait_sig(0, 20, n); chk("start_after_rst", n, 4);
`ifdef GAME_SPEEDUP_EN
    wait_sig(3, 200, n); chk("speed_base", n, 80);
    @(negedge clk);
    repeat (8) begin lc3 = 1; @(negedge clk); lc3 = 0; @(negedge clk); end
    wait_sig(3, 200, n);
    wait_sig(3, 200, n); chk("speed_40", n, 40);
    @(negedge clk);
    repeat (16) begin lc3 = 1; @(negedge clk); lc3 = 0; @(negedge clk); end
    wait_sig(3, 200, n);
    wait_sig(3, 200, n); chk("speed_10", n, 10);
    @(negedge clk);
    repeat (16) begin lc3 = 1; @(negedge clk); lc3 = 0; @(negedge clk); end
    chk("speed_score", int'(bs.score), 40);
    wait_sig(3, 200, n);
    wait_sig(3, 200, n); chk("speed_floor", n, 10);
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Sequencer for the block-drop game datapath. It owns the game state machine (START/PLAY/OVER) and the fall-tick timebase, and it converts raw keys into per-tick move requests. It also keeps the line score. It sits between the board I/O and the board datapath: it drives `game_state`, the tick and the move requests into the datapath, and it consumes the datapath's `game_over` and line-clear indications.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per fall tick (≥4).
- `OVER_HOLD`, 2: number of full ticks OVER must last before a restart is accepted.
- `SCORE_W`, 8: score width.

- `CLK_50M` in 1: system clock.
- `RST_N` in 1: reset; asynchronous, active-low.
- `start_key` in 1: raw start/restart key, asynchronous.
- `left_key`, `right_key`, `down_key` in 1 each: raw move keys, asynchronous.
- `game_over` in 1: datapath reports the board is blocked; level.
- `line_cleared` in 1: datapath one-cycle pulse per cleared row.
- `game_state` out 2: 00 START, 01 PLAY, 10 OVER; 11 is never driven.
- `tick` out 1: one-cycle fall strobe, PLAY only.
- `left_req`, `right_req`, `down_req` out 1 each: move requests, valid only while `tick`=1.
- `score` out `SCORE_W`: cleared-line count.

## Operation
- **Key front end:**
  - Each raw key passes through a 2-flop synchronizer and then a rising-edge detector.
  - Edges are recognized 3 cycles after the raw rise.
  - A held key yields exactly one edge.
- **State machine:**
  - START→PLAY on a `start_key` edge.
  - PLAY→OVER on the first cycle `game_over`=1.
  - OVER→START on a `start_key` edge, but only once `OVER_HOLD` ticks have elapsed in OVER. Earlier edges are ignored.
  - An illegal encoding 11 goes to START on the next cycle.
- **Tick counter:**
  - Counts 0..period−1 in PLAY and in OVER; `tick`=1 in the cycle the counter equals period−1, then the counter wraps to 0.
  - Cleared to 0 on every state entry.
  - Held at 0 in START.
- **Tick output:**
  - `tick` is an output in PLAY only.
  - In OVER the count is internal and used only for the hold counter.
- **Move latches:**
  - Left, right and down each have a sticky request flag.
  - A flag sets on its key edge and clears in the cycle after `tick`.
  - A left edge clears a pending right flag, and vice versa.
  - Simultaneous left and right edges in the same cycle cancel: both flags end up 0.
  - Flags are cleared on any state change.
  - `*_req` = flag AND `tick`.
- **Score:**
  - +1 per `line_cleared` pulse, in PLAY only.
  - Saturates at 2^SCORE_W−1.
  - Cleared on the START→PLAY transition; holds its value through OVER and START.
- **Overlapping events in PLAY:**
  - `game_over` and `tick` in the same cycle: state goes to OVER and this last tick is still emitted.
  - `line_cleared` and `game_over` in the same cycle: the score still increments.

## Timing
- Reset values: `game_state`=00, `tick`=0, all `*_req`=0, `score`=0, all counters and flags 0, synchronizer flops 0.
- All outputs are registered.
- `game_state` changes 1 cycle after the qualifying edge or `game_over` sample.
- Tick timing:
  - The first tick occurs exactly period cycles after `game_state` becomes 01.
  - Later ticks follow every period cycles.
- A key edge recognized in the same cycle as `tick` is not presented on that tick; it waits for the next one.
- `score` updates 1 cycle after `line_cleared`.
- Reset mid-operation: all state is cleared immediately and asynchronously. The state machine restarts in START.

## Configuration
- `GAME_SPEEDUP_EN` defined:
  - period = `TICK_DIV` >> min(`score`>>3, 3).
  - The fall rate doubles every 8 lines, up to 8× the base rate.
  - The new period is latched only at counter wrap and at state entry, never mid-count.
- Undefined: period = `TICK_DIV` constant; the speedup logic is absent.

## Structure
- Shared package `game_pkg`:
  - State localparams `STATE_START`/`STATE_PLAY`/`STATE_OVER`.
  - Color constants BLUE/GREEN/RED/WHITE/BLACK.
  - The datapath already uses these; both blocks import them from `game_pkg`.
- Sub-module `key_edge_sync`: 2-flop synchronizer plus rising-edge pulse.
  - Instantiated four times.

## Test plan
All scenarios use `TICK_DIV`=10 and `OVER_HOLD`=2.
- **Start and tick cadence:** reset, then pulse `start_key`. Expect `game_state`=01 4 cycles after the raw rise. First `tick` exactly 10 cycles later, then every 10 cycles.
- **Move latch and cancellation:**
  - Left edge mid-period → `left_req`=1 only in the next tick cycle.
  - Left and right edges in the same cycle → no requests on the next tick.
  - Right edge after a left edge → only `right_req`.
- **Game over and restart hold:**
  - `game_over`=1 → `game_state`=10 next cycle and `tick` stays 0.
  - `start_key` edge 5 cycles later is ignored.
  - `start_key` edge after 20 cycles → 00.
- **Score:**
  - 3 `line_cleared` pulses in PLAY → `score`=3.
  - Pulses in START have no effect.
  - `SCORE_W`=2 with 5 pulses → `score`=3.
  - New game → `score`=0.
- **Speedup (`GAME_SPEEDUP_EN`, `TICK_DIV`=80):**
  - `score` 8 → period 40 from the next wrap.
  - `score` ≥24 → period 10 and does not shorten further.
- **Reset mid-PLAY:** assert `RST_N`=0 mid-count → all outputs go to their reset values asynchronously. After release, START holds until a `start_key` edge.
